// File: rtl/mc_stream_loader.sv
// mc_stream_loader: word-stream front end for the 4x4 SIMD PE array.
//
// Collects 16 A words and 16 B words into the 512-bit operands, pulses
// pe_clear, holds enable for COMPUTE_CYCLES cycles, captures Matrix_C and
// streams it back out as 16 words under valid/ready.
//
// Build option: define MC_B_TRANSPOSE_EN to store B column-major (row-major
// arrival, word i written to slot 4*(i%4)+(i/4)). Undefined: linear, like A.
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | waiting for the first A word, in_ready high
//   LOAD_A   | collecting A words 1..15
//   LOAD_B   | collecting B words 0..15
//   CLEAR    | single-cycle pe_clear pulse to the array
//   RUN      | enable held high for COMPUTE_CYCLES cycles
//   CAPTURE  | single cycle, Matrix_C registered, first result word staged
//   DRAIN    | 16 result words out under valid/ready, done on the last

module mc_stream_loader #(
    parameter int DATA_W         = 32,   // fixed at 32 in this revision
    parameter int COMPUTE_CYCLES = 4     // 1..15
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic [16*DATA_W-1:0]  Matrix_A,
    output logic [16*DATA_W-1:0]  Matrix_B,
    output logic                  pe_clear,
    output logic                  enable,
    input  logic [16*DATA_W-1:0]  Matrix_C,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_RUN     = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    state_t                 state;
    logic [3:0]             word_cnt;
    logic [3:0]             word_nxt;
    logic [3:0]             b_slot;
    logic [3:0]             cyc_cnt;
    logic [16*DATA_W-1:0]   cap_reg;
    logic                   in_acc;
    logic                   out_acc;

    // Word k lives at [511-32k -: 32]; the LSB of that slot is 32*(15-k),
    // which for a 4-bit k is simply {~k, 5'b0}.
    function automatic logic [8:0] slot_lsb(input logic [3:0] idx);
        return {~idx, 5'd0};
    endfunction

    // Handshake decodes and counter increment.
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign word_nxt = word_cnt + 4'd1;

`ifdef MC_B_TRANSPOSE_EN
    // Row-major arrival: r = i/4, c = i%4, stored at 4*c + r.
    assign b_slot = {word_cnt[1:0], word_cnt[3:2]};
`else
    assign b_slot = word_cnt;
`endif

    // done is a decode of the final output handshake so it lands in the
    // accept cycle itself, while in_ready is still low; busy drops next cycle.
    assign done = (state == ST_DRAIN) && out_acc && (word_cnt == 4'd15);

    // Sequencer: state, counters, operand/capture registers and all
    // registered outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            word_cnt  <= 4'd0;
            cyc_cnt   <= 4'd0;
            cap_reg   <= '0;
            Matrix_A  <= '0;
            Matrix_B  <= '0;
            in_ready  <= 1'b0;
            pe_clear  <= 1'b0;
            enable    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_acc) begin
                        Matrix_A[slot_lsb(word_cnt) +: DATA_W] <= in_data;
                        word_cnt <= word_nxt;
                        busy     <= 1'b1;
                        state    <= ST_LOAD_A;
                    end
                end

                ST_LOAD_A: begin
                    if (in_acc) begin
                        Matrix_A[slot_lsb(word_cnt) +: DATA_W] <= in_data;
                        word_cnt <= word_nxt;
                        if (word_cnt == 4'd15) begin
                            state <= ST_LOAD_B;
                        end
                    end
                end

                ST_LOAD_B: begin
                    if (in_acc) begin
                        Matrix_B[slot_lsb(b_slot) +: DATA_W] <= in_data;
                        word_cnt <= word_nxt;
                        if (word_cnt == 4'd15) begin
                            in_ready <= 1'b0;
                            pe_clear <= 1'b1;
                            state    <= ST_CLEAR;
                        end
                    end
                end

                ST_CLEAR: begin
                    pe_clear <= 1'b0;
                    enable   <= 1'b1;
                    cyc_cnt  <= 4'(COMPUTE_CYCLES - 1);
                    state    <= ST_RUN;
                end

                ST_RUN: begin
                    if (cyc_cnt == 4'd0) begin
                        enable <= 1'b0;
                        state  <= ST_CAPTURE;
                    end else begin
                        cyc_cnt <= cyc_cnt - 4'd1;
                    end
                end

                ST_CAPTURE: begin
                    // Stage word 0 straight from the array so out_valid and
                    // out_data rise together on the capture edge.
                    cap_reg   <= Matrix_C;
                    out_data  <= Matrix_C[slot_lsb(4'd0) +: DATA_W];
                    out_valid <= 1'b1;
                    state     <= ST_DRAIN;
                end

                ST_DRAIN: begin
                    if (out_acc) begin
                        if (word_cnt == 4'd15) begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            word_cnt  <= 4'd0;
                            cyc_cnt   <= 4'd0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            out_data <= cap_reg[slot_lsb(word_nxt) +: DATA_W];
                            word_cnt <= word_nxt;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    word_cnt  <= 4'd0;
                    cyc_cnt   <= 4'd0;
                    in_ready  <= 1'b0;
                    pe_clear  <= 1'b0;
                    enable    <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_stream_loader.sv
// Self-checking bench for mc_stream_loader: table-driven operations plus a
// hand-written mid-load reset sequence. Result words are scoreboarded.
module tb_mc_stream_loader;

    logic         CLK = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic [511:0] Matrix_A;
    logic [511:0] Matrix_B;
    logic         pe_clear;
    logic         enable;
    logic [511:0] Matrix_C = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         busy;
    logic         done;

    mc_stream_loader #(.DATA_W(32), .COMPUTE_CYCLES(4)) dut (
        .CLK(CLK), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .Matrix_A(Matrix_A), .Matrix_B(Matrix_B),
        .pe_clear(pe_clear), .enable(enable), .Matrix_C(Matrix_C),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a_base;
        logic [31:0] b_base;
        logic [31:0] c_base;
        int          gap_mode;     // 0 none, 1 alternate + long stall, 2 random
        int          ready_mode;   // 0 always, 1 pattern 1,0,0,1, 2 random
        bit          junk;         // drive in_valid outside the load states
        logic [31:0] exp_a_first;
        logic [31:0] exp_a_last;
        logic [31:0] exp_b_first;
        logic [31:0] exp_b_last;
    } vec_t;

    vec_t        vecs[3];
    int          checks = 0;
    int          errors = 0;
    int          done_total = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count done pulses seen anywhere in the run.
    always begin
        @(negedge CLK);
        #2;
        if (done === 1'b1) done_total++;
    end

    function automatic int b_slot(input int i);
`ifdef MC_B_TRANSPOSE_EN
        return 4 * (i % 4) + i / 4;
`else
        return i;
`endif
    endfunction

    task automatic send_word(input logic [31:0] d, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (in_ready === 1'b1) begin
                in_valid = 1'b1;
                in_data  = d;
                @(posedge CLK);
                #1;
                in_valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input int vi);
        vec_t         v;
        logic [511:0] ea, eb, ec;
        logic [6:0]   tr_clr, tr_en, tr_ov, tr_busy, tr_ir;
        int           accepted, it, dcnt;
        bit           ok, stalled;
        logic [31:0]  held, e, w_data;
        v = vecs[vi];
        ea = '0; eb = '0; ec = '0;
        for (int i = 0; i < 16; i++) begin
            ea[511 - 32*i -: 32]         = v.a_base + i;
            eb[511 - 32*b_slot(i) -: 32] = v.b_base + i;
            ec[511 - 32*i -: 32]         = v.c_base + i;
        end
        Matrix_C = ~ec;
        accepted = 0;
        for (int w = 0; w < 32; w++) begin
            if (v.gap_mode == 1) begin
                if (w % 2 == 1) repeat (1) @(negedge CLK);
                if (w == 20) repeat (10) @(negedge CLK);
            end else if (v.gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) @(negedge CLK);
            end
            w_data = (w < 16) ? v.a_base + w : v.b_base + (w - 16);
            send_word(w_data, ok);
            if (ok) accepted++;
        end
        check("load_count", accepted, 32);
        if (v.junk) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD_BEEF;
        end
        // Cycle-by-cycle trace from the last B accept.
        for (int n = 1; n <= 7; n++) begin
            @(negedge CLK);
            #1;
            tr_clr[n-1]  = pe_clear;
            tr_en[n-1]   = enable;
            tr_ov[n-1]   = out_valid;
            tr_busy[n-1] = busy;
            tr_ir[n-1]   = in_ready;
            if (n == 1) begin
                check("matrix_a", Matrix_A, ea);
                check("matrix_b", Matrix_B, eb);
                check("a_first", Matrix_A[511:480], v.exp_a_first);
                check("a_last", Matrix_A[31:0], v.exp_a_last);
                check("b_first", Matrix_B[511:480], v.exp_b_first);
                check("b_last", Matrix_B[31:0], v.exp_b_last);
`ifdef MC_B_TRANSPOSE_EN
                check("b_transpose_slot1", Matrix_B[479:448], v.b_base + 4);
                check("b_transpose_slot3", Matrix_B[415:384], v.b_base + 12);
`endif
            end
            if (n == 5) begin
                // Result is only valid around the capture window.
                Matrix_C = ec;
                for (int j = 0; j < 16; j++) exp_q.push_back(v.c_base + j);
            end
        end
        Matrix_C = ~ec;
        in_valid = 1'b0;
        check("trace_pe_clear", tr_clr, 7'b0000001);
        check("trace_enable", tr_en, 7'b0011110);
        check("trace_out_valid", tr_ov, 7'b1000000);
        check("trace_busy", tr_busy, 7'b1111111);
        check("trace_in_ready", tr_ir, 7'b0000000);
        // Drain with scoreboard.
        it = 0; dcnt = 0; stalled = 1'b0; held = '0;
        while (exp_q.size() > 0 && it < 200) begin
            if (it > 0) @(negedge CLK);
            case (v.ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (it % 4 == 0) || (it % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            check("out_valid_drain", out_valid, 1'b1);
            if (stalled) check("stall_hold", out_data, held);
            if (out_ready) begin
                e = exp_q.pop_front();
                check("out_data", out_data, e);
                check("done_flag", done, exp_q.size() == 0);
            end
            if (done === 1'b1) dcnt++;
            stalled = !out_ready;
            held    = out_data;
            it++;
        end
        check("drain_complete", exp_q.size(), 0);
        check("done_count", dcnt, 1);
        exp_q.delete();
        @(negedge CLK);
        out_ready = 1'b0;
        #1;
        check("post_busy", busy, 1'b0);
        check("post_done", done, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
        check("post_out_valid", out_valid, 1'b0);
        check("hold_matrix_a", Matrix_A, ea);
        check("hold_matrix_b", Matrix_B, eb);
    endtask

    initial begin
        logic [511:0] ea_part;
        bit           ok;
        int           accepted;

        vecs[0] = '{32'd1, 32'd17, 32'hC0, 0, 0, 1'b0,
                    32'd1, 32'd16, 32'd17, 32'd32};
        vecs[1] = '{32'h100, 32'h200, 32'hD00, 1, 1, 1'b1,
                    32'h100, 32'h10F, 32'h200, 32'h20F};
        vecs[2] = '{32'hFFFF_FFF0, 32'h8000_0000, 32'h1234_0000, 2, 2, 1'b1,
                    32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_000F};

        // Reset state.
        repeat (2) @(negedge CLK);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_matrix_a", Matrix_A, '0);
        check("rst_matrix_b", Matrix_B, '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        #1;
        check("rel_in_ready", in_ready, 1'b1);

        for (int k = 0; k < 3; k++) run_op(k);

        // Reset in the middle of the B load.
        ea_part = '0;
        for (int i = 0; i < 16; i++) ea_part[511 - 32*i -: 32] = 32'h5000 + i;
        accepted = 0;
        for (int w = 0; w < 21; w++) begin
            send_word((w < 16) ? 32'h5000 + w : 32'h6000 + w, ok);
            if (ok) accepted++;
        end
        check("mid_load_count", accepted, 21);
        @(negedge CLK);
        #1;
        check("mid_matrix_a", Matrix_A, ea_part);
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mrst_in_ready", in_ready, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_matrix_a", Matrix_A, '0);
        check("mrst_matrix_b", Matrix_B, '0);
        check("mrst_pe_clear", pe_clear, 1'b0);
        check("mrst_enable", enable, 1'b0);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_out_data", out_data, '0);
        check("mrst_done", done, 1'b0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        #1;
        check("mrel_in_ready", in_ready, 1'b1);
        check("mrel_busy", busy, 1'b0);

        run_op(0);

        check("done_total", done_total, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_stream_loader.md
Name: mc_stream_loader

Overview:
- Upstream/downstream controller for the 4x4 SIMD PE array in the 32-bit matrix calculator.
- Accepts a 32-bit word stream and assembles the 512-bit Matrix_A and Matrix_B operands from it.
- Sequences the array's clear and enable, captures the 512-bit Matrix_C result, and streams it back out as 16 words under valid/ready.
- Sits between the host-side word interface and the SIMD block.

Parameters:
- DATA_W, 32, element width. Fixed at 32 in this revision.
- COMPUTE_CYCLES, 4, number of consecutive cycles enable is held high per operation. Legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  32  operand word. 16 A words first, then 16 B words.
- Matrix_A  out  512  assembled A operand, to the SIMD array.
- Matrix_B  out  512  assembled B operand, to the SIMD array.
- pe_clear  out  1  one-cycle clear pulse to the PE array before compute.
- enable  out  1  PE array enable.
- Matrix_C  in  512  result from the SIMD array.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts a result word.
- out_data  out  32  result word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the 16th result word is accepted.

Behaviour:
- Reset (reset=0, async) values:
  - All outputs 0, including Matrix_A, Matrix_B, out_data and the capture register.
  - State IDLE, word counter 0.
  - Deasserting reset leaves in_ready=1 on the next cycle.
- States and transitions: IDLE, LOAD_A, LOAD_B, CLEAR, RUN, CAPTURE, DRAIN.
- IDLE:
  - in_ready=1.
  - An accepted word (in_valid and in_ready) is stored as A word 0, the counter goes to 1, and the state moves to LOAD_A.
- Word mapping: word i (0..15) is written to bits [511-32*i -: 32], so word 0 lands at [511:480] and word 15 at [31:0].
- LOAD_A:
  - in_ready=1; each accepted word is written to Matrix_A and the counter increments.
  - The accept at count 15 wraps the counter to 0 and moves to LOAD_B.
- LOAD_B:
  - Same as LOAD_A, but writing Matrix_B.
  - The accept at count 15 moves to CLEAR.
- CLEAR:
  - Exactly 1 cycle; pe_clear=1, enable=0, in_ready=0.
- RUN:
  - enable=1 for exactly COMPUTE_CYCLES cycles, tracked by a cycle counter.
  - in_ready=0; Matrix_A and Matrix_B are held stable.
- CAPTURE:
  - Exactly 1 cycle; enable=0.
  - Matrix_C is registered into the capture register on this edge.
- DRAIN:
  - out_valid=1; out_data = capture word j, same mapping as the load.
  - On out_valid and out_ready, j increments.
  - out_data and out_valid hold while out_ready=0.
  - The accept of j=15 pulses done, returns to IDLE and clears the counters.
- Minimum latency, from the accept of the last B word to the first out_valid: COMPUTE_CYCLES+2 cycles (default 6).
- in_valid outside the load states is ignored, with no side effects.
- in_valid=0 mid-load stalls the load indefinitely; partially loaded words are kept.
- Matrix_A and Matrix_B keep their last values after the operation; they are overwritten only by new loads.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs zeroed.
  - A partial load is discarded; no done pulse is generated.
- Simultaneous done and in_valid: no word is accepted in the done cycle, because in_ready=0 in DRAIN. The next operation starts the following cycle.

Optional Feature:
- Macro: MC_B_TRANSPOSE_EN.
- Defined:
  - B words arrive row-major, r=i/4 and c=i%4, and are stored transposed at index 4*c+r.
  - Matrix_B slice k therefore holds column k of B.
- Undefined: B uses the same linear mapping as A. No extra logic or ports either way.

Test Plan:
- Word mapping: load A words 1..16 and B words 17..32, back to back -> Matrix_A[511:480]=1, Matrix_A[31:0]=16, Matrix_B[511:480]=17, Matrix_B[31:0]=32.
- Sequencing: same load, capture a trace -> pe_clear high for 1 cycle; enable high for exactly 4 consecutive cycles starting the cycle after pe_clear; Matrix_C sampled once; first out_valid 6 cycles after the last B accept.
- Drain order: stub Matrix_C = word j holds 0xC0+j -> out_data 0xC0..0xCF in order; done pulses once on the 16th accept; busy falls the next cycle.
- Backpressure and stalls:
  - out_ready toggled 1,0,0,1 -> no word duplicated or skipped; out_data stable while stalled.
  - in_valid gaps during load -> identical Matrix_A and Matrix_B contents.
- Reset mid-operation: assert reset after 5 B words -> all outputs 0 immediately, no done; a fresh 32-word load then completes correctly.
- With MC_B_TRANSPOSE_EN defined, B words 0..15 -> Matrix_B[511:480]=0, [479:448]=4, [447:416]=8, [415:384]=12, [31:0]=15.
